// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/EXEC/MEM/HALT with one branch delay slot.
// Optional: define INSTR_SEQ_ALIGN_CHECK_EN to trap misaligned branch targets into HALT.
module instr_sequencer #(
  parameter int                 ADDR_W       = 32,
  parameter logic [31:0]        RESET_VECTOR = 32'hBFC00000,
  parameter logic [ADDR_W-1:0]  HALT_ADDR    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [31:0]       instr_readdata,
  input  logic              mem_access,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [1:0]        state,
  output logic [ADDR_W-1:0] instr_address,
  output logic [31:0]       instruction_word,
  output logic              delay_slot,
  output logic              finish,
  output logic              align_err
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_MEM   = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VECTOR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              delay_slot_q, delay_slot_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic              finish_q, finish_d;
`ifdef INSTR_SEQ_ALIGN_CHECK_EN
  logic              align_err_q, align_err_d;
`endif

  logic              complete;
  logic              halt_now;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;

  // Flow control: stall=1 freezes every register for that cycle; stall=0 lets
  // the current state advance. There is no other handshake on this block.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    delay_slot_d  = delay_slot_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    finish_d      = finish_q;
`ifdef INSTR_SEQ_ALIGN_CHECK_EN
    align_err_d   = align_err_q;
`endif
    complete      = 1'b0;
    halt_now      = 1'b0;
    pc_inc        = pc_q + ADDR_W'(4);
    next_pc       = pc_inc;

    case (state_q)
      ST_FETCH: begin
        if (!stall) begin
          ir_d         = instr_readdata;
          delay_slot_d = pend_valid_q;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          // A branch inside a delay slot is dropped: the first redirect wins.
          if (branch_taken && !delay_slot_q && !pend_valid_q) begin
            pend_valid_d = 1'b1;
`ifdef INSTR_SEQ_ALIGN_CHECK_EN
            pend_target_d = branch_target;
`else
            pend_target_d = branch_target & ~ADDR_W'(3);
`endif
          end
          if (mem_access) state_d = ST_MEM;
          else            complete = 1'b1;
        end
      end
      ST_MEM: begin
        if (!stall) complete = 1'b1;
      end
      default: ;
    endcase

    if (complete) begin
      if (delay_slot_q) begin
        next_pc      = pend_target_q;
        pend_valid_d = 1'b0;
        delay_slot_d = 1'b0;
`ifdef INSTR_SEQ_ALIGN_CHECK_EN
        if (pend_target_q[1:0] != 2'b00) begin
          align_err_d = 1'b1;
          halt_now    = 1'b1;
          next_pc     = pc_inc;
        end
`endif
      end
      pc_d = next_pc;
      if (halt_now || (next_pc == HALT_ADDR)) begin
        state_d  = ST_HALT;
        finish_d = 1'b1;
      end else begin
        state_d  = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RST_PC;
      ir_q          <= '0;
      delay_slot_q  <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      finish_q      <= 1'b0;
`ifdef INSTR_SEQ_ALIGN_CHECK_EN
      align_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      delay_slot_q  <= delay_slot_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      finish_q      <= finish_d;
`ifdef INSTR_SEQ_ALIGN_CHECK_EN
      align_err_q   <= align_err_d;
`endif
    end
  end

  assign state            = state_q;
  assign instr_address    = pc_q;
  assign instruction_word = ir_q;
  assign delay_slot       = delay_slot_q;
  assign finish           = finish_q;
`ifdef INSTR_SEQ_ALIGN_CHECK_EN
  assign align_err        = align_err_q;
`else
  assign align_err        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer; a monitor checks every EXEC entry against a queue.
module tb_instr_sequencer;

  localparam logic [1:0]  S_FETCH = 2'b00;
  localparam logic [1:0]  S_EXEC  = 2'b01;
  localparam logic [1:0]  S_MEM   = 2'b10;
  localparam logic [1:0]  S_HALT  = 2'b11;
  localparam logic [31:0] KEY     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        mem_access = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] instr_readdata;
  logic [1:0]  state;
  logic [31:0] instr_address;
  logic [31:0] instruction_word;
  logic        delay_slot;
  logic        finish;
  logic        align_err;

  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  // Instruction memory model: word content derived from its address.
  assign instr_readdata = instr_address ^ KEY;

  instr_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .instr_readdata   (instr_readdata),
    .mem_access       (mem_access),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .state            (state),
    .instr_address    (instr_address),
    .instruction_word (instruction_word),
    .delay_slot       (delay_slot),
    .finish           (finish),
    .align_err        (align_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic do_reset();
    check("queue_drained", exp_q.size(), 0);
    reset = 1'b0;
    stall = 1'b0;
    mem_access = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    step();
    step();
    check("rst_state", {30'd0, state}, {30'd0, S_FETCH});
    check("rst_addr", instr_address, 32'hBFC00000);
    check("rst_ir", instruction_word, 32'h0);
    check("rst_ds", {31'd0, delay_slot}, 32'd0);
    check("rst_finish", {31'd0, finish}, 32'd0);
    check("rst_align", {31'd0, align_err}, 32'd0);
    reset = 1'b1;
  endtask

  task automatic do_instr(input logic mem, input logic br, input logic [31:0] tgt,
                          input logic [31:0] exp_addr, input logic exp_ds, input int exp_cycles);
    int  cyc;
    bit  seen_exec;
    bit  seen_mem;
    exp_q.push_back({exp_addr, exp_addr ^ KEY, exp_ds});
    check("fetch_addr", instr_address, exp_addr);
    mem_access = mem;
    branch_taken = br;
    branch_target = tgt;
    cyc = 0;
    seen_exec = 0;
    seen_mem = 0;
    while (cyc < 50) begin
      step();
      cyc++;
      if (state == S_EXEC) seen_exec = 1;
      if (state == S_MEM) seen_mem = 1;
      if (seen_exec && (state == S_FETCH || state == S_HALT)) break;
    end
    mem_access = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    check("instr_cycles", cyc, exp_cycles);
    check("mem_cycle_seen", {31'd0, seen_mem}, {31'd0, mem});
  endtask

  // Scoreboard monitor: one transaction per instruction, taken on EXEC entry.
  logic [1:0]  prev_state = S_FETCH;
  logic [64:0] exp_item;
  always @(negedge clk) begin
    if (!reset) begin
      prev_state = S_FETCH;
    end else begin
      if (state == S_EXEC && prev_state != S_EXEC) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_exec actual_addr=%h expected=none", instr_address);
        end else begin
          exp_item = exp_q.pop_front();
          if ({instr_address, instruction_word, delay_slot} !== exp_item) begin
            failures++;
            $display("FAIL exec_entry actual addr=%h ir=%h ds=%b expected addr=%h ir=%h ds=%b",
                     instr_address, instruction_word, delay_slot,
                     exp_item[64:33], exp_item[32:1], exp_item[0]);
          end
        end
      end
      prev_state = state;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;

    // Straight-line sequence, two cycles per instruction
    do_reset();
    do_instr(0, 0, 32'h0, 32'hBFC00000, 0, 2);
    do_instr(0, 0, 32'h0, 32'hBFC00004, 0, 2);
    check("seq_addr3", instr_address, 32'hBFC00008);

    // MEM cycle on the second instruction; PC moves only after MEM
    do_reset();
    do_instr(0, 0, 32'h0, 32'hBFC00000, 0, 2);
    exp_q.push_back({32'hBFC00004, 32'hBFC00004 ^ KEY, 1'b0});
    mem_access = 1'b1;
    step();
    check("mem_s_exec", {30'd0, state}, {30'd0, S_EXEC});
    step();
    check("mem_s_mem", {30'd0, state}, {30'd0, S_MEM});
    check("mem_pc_held", instr_address, 32'hBFC00004);
    mem_access = 1'b0;
    step();
    check("mem_s_fetch", {30'd0, state}, {30'd0, S_FETCH});
    check("mem_pc_next", instr_address, 32'hBFC00008);

    // Branch with delay slot; a second branch in the slot is ignored
    do_reset();
    do_instr(0, 0, 32'h0,         32'hBFC00000, 0, 2);
    do_instr(0, 1, 32'hBFC00100,  32'hBFC00004, 0, 2);
    do_instr(1, 1, 32'hBFC00200,  32'hBFC00008, 1, 3);
    do_instr(0, 0, 32'h0,         32'hBFC00100, 0, 2);
    check("br_after", instr_address, 32'hBFC00104);
    check("br_ds_clear", {31'd0, delay_slot}, 32'd0);

    // Branch to the halt address; HALT ignores stall/branch/mem
    do_reset();
    do_instr(0, 1, 32'h00000000, 32'hBFC00000, 0, 2);
    do_instr(0, 0, 32'h0,        32'hBFC00004, 1, 2);
    check("halt_state", {30'd0, state}, {30'd0, S_HALT});
    check("halt_finish", {31'd0, finish}, 32'd1);
    check("halt_pc", instr_address, 32'h0);
    for (int i = 0; i < 6; i++) begin
      stall = i[0];
      branch_taken = 1'b1;
      branch_target = 32'hBFC00300;
      mem_access = 1'b1;
      step();
      check("halt_hold_state", {30'd0, state}, {30'd0, S_HALT});
      check("halt_hold_pc", instr_address, 32'h0);
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    mem_access = 1'b0;

    // Stall in EXEC, then asynchronous reset in the middle of the stall
    do_reset();
    do_instr(0, 0, 32'h0, 32'hBFC00000, 0, 2);
    exp_q.push_back({32'hBFC00004, 32'hBFC00004 ^ KEY, 1'b0});
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_state", {30'd0, state}, {30'd0, S_EXEC});
      check("stall_pc", instr_address, 32'hBFC00004);
      check("stall_ir", instruction_word, 32'hBFC00004 ^ KEY);
    end
    #2 reset = 1'b0;
    #1;
    check("midrst_state", {30'd0, state}, {30'd0, S_FETCH});
    check("midrst_pc", instr_address, 32'hBFC00000);
    check("midrst_ir", instruction_word, 32'h0);
    step();
    step();
    stall = 1'b0;
    reset = 1'b1;
    do_instr(0, 0, 32'h0, 32'hBFC00000, 0, 2);

    // Misaligned branch target
    do_reset();
    do_instr(0, 1, 32'hBFC00102, 32'hBFC00000, 0, 2);
    do_instr(0, 0, 32'h0,        32'hBFC00004, 1, 2);
`ifdef INSTR_SEQ_ALIGN_CHECK_EN
    check("align_state", {30'd0, state}, {30'd0, S_HALT});
    check("align_err", {31'd0, align_err}, 32'd1);
    check("align_finish", {31'd0, finish}, 32'd1);
    check("align_pc", instr_address, 32'hBFC00008);
`else
    check("align_err", {31'd0, align_err}, 32'd0);
    do_instr(0, 0, 32'h0, 32'hBFC00100, 0, 2);
    check("align_err_after", {31'd0, align_err}, 32'd0);
`endif
    step();
    check("final_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
